// File: rtl/xsoc_bus_master.sv
// xSoc bus initiator: turns one CPU request into an as_/rdy_ bus access with a
// turnaround cycle and an optional ACCESS timeout so a missing slave cannot hang the CPU.
module xsoc_bus_master #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              xsoc_bus_clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic [1:0]        dbg_state
);

    // Handshake: the CPU side has no ready; req is only looked at while busy is low,
    // and each accepted request produces exactly one ack pulse (with err on timeout).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_e;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic                as_q, as_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        as_d    = as_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                as_d = 1'b1;
                if (req) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    wdata_d = req_wr_data;
                    as_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A ready slave beats the timeout when both land on the same cycle.
                if (!bus_rdy_) begin
                    as_d  = 1'b1;
                    ack_d = 1'b1;
                    if (rw_q) begin
                        rdata_d = bus_rd_data;
                    end
                    state_d = TURN;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    as_d    = 1'b1;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = TURN;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                // The slave's registered rdy_ can still be low here; it is not looked at.
                as_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                as_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge xsoc_bus_clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            as_q    <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            as_q    <= as_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign rd_data     = rdata_q;
    assign bus_as_     = as_q;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;
    assign dbg_state   = state_q;

endmodule
